// File: rtl/fir_pkg.sv
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared types and arithmetic helpers for the serial-MAC FIR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DEF_IN_W   = 15;
  localparam int DEF_COEF_W = 15;
  localparam int DEF_OUT_W  = 20;

  // Accumulator width that cannot overflow over TAPS full-precision products
  function automatic int acc_width(input int in_w, input int coef_w, input int taps);
    return in_w + coef_w + $clog2(taps);
  endfunction

  // Arithmetic right shift with round-half-up, then clip to a signed out_w range
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int shift,
                                                   input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    else           r = acc;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi)      return hi;
    else if (r < lo) return lo;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_coef_rf.sv
// ============================================================================
// Module   : fir_coef_rf
// Purpose  : TAPS x COEF_W coefficient register file, one write port and one
//            combinational read port indexed by the current tap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_coef_rf #(
  parameter int TAPS   = 11,
  parameter int COEF_W = 15,
  parameter int AW     = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [COEF_W-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic signed [COEF_W-1:0] rdata
);

  localparam logic [AW:0] TAPS_X = (AW + 1)'(TAPS);

  logic signed [COEF_W-1:0] mem [TAPS];

  // Out-of-range addresses are silently ignored so no phantom entry exists
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
    end else if (we && ({1'b0, waddr} < TAPS_X)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fir_serial_mac.sv
// ============================================================================
// Module   : fir_serial_mac
// Purpose  : Time-multiplexed single-multiplier FIR with valid/ready on both
//            sides, runtime-loadable taps and a rounded, saturated output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_serial_mac
  import fir_pkg::*;
#(
  parameter  int IN_W   = DEF_IN_W,
  parameter  int COEF_W = DEF_COEF_W,
  parameter  int OUT_W  = DEF_OUT_W,
  parameter  int TAPS   = 11,
  parameter  int SHIFT  = 0,
  localparam int ACC_W  = acc_width(IN_W, COEF_W, TAPS),
  localparam int AW     = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IN_W-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_ready
);

  localparam int            PROD_W = IN_W + COEF_W;
  localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
  localparam logic [AW-1:0] TAPS_M = AW'(TAPS);

  state_t                   state;
  logic signed [IN_W-1:0]   dline [TAPS];
  logic [AW-1:0]            wptr;
  logic [AW-1:0]            k;
  logic [AW-1:0]            rd_idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] prod;
  logic                     coef_wr;

  // Both sides are only open while waiting for a sample
  assign in_ready   = (state == IDLE) && !rst;
  assign coef_ready = in_ready;
  assign coef_wr    = coef_we && coef_ready;

  fir_coef_rf #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W),
    .AW     (AW)
  ) u_coef_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (coef_wr),
    .waddr  (coef_addr),
    .wdata  (coef_data),
    .raddr  (k),
    .rdata  (coef)
  );

  // Tap k looks k samples back from the newest entry, wrapping modulo TAPS;
  // the modulo-2^AW add of TAPS is exact because the true index is < TAPS
  always_comb begin
    rd_idx = wptr - k;
    if (wptr < k) rd_idx = rd_idx + TAPS_M;
  end

  assign prod     = PROD_W'(dline[rd_idx]) * PROD_W'(coef);
  assign acc_next = acc + ACC_W'(prod);

  // Sample accept, per-tap accumulation and output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      k         <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < TAPS; i++) dline[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dline[wptr] <= in_data;
            acc         <= '0;
            k           <= '0;
            state       <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (k == LAST) begin
            out_data  <= OUT_W'(sat_round(64'(acc_next), SHIFT, OUT_W));
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            k <= k + AW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            wptr      <= (wptr == LAST) ? '0 : wptr + AW'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_serial_mac.sv
// ============================================================================
// Module   : tb_fir_serial_mac
// Purpose  : Directed bench for fir_serial_mac with a reference model feeding
//            expected-output queues (SHIFT=0 and SHIFT=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fir_serial_mac;

  localparam int IN_W   = 15;
  localparam int COEF_W = 15;
  localparam int OUT_W  = 20;
  localparam int TAPS   = 11;
  localparam int AW     = $clog2(TAPS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic coef_we = 1'b0;
  logic signed [IN_W-1:0]   in_data = '0;
  logic [AW-1:0]            coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic in_ready, out_valid, coef_ready;
  logic r_in_ready, r_out_valid, r_coef_ready;
  logic signed [OUT_W-1:0] out_data, r_out_data;

  always #5 clk = ~clk;

  fir_serial_mac #(.IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .TAPS(TAPS), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_ready(coef_ready));

  fir_serial_mac #(.IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .TAPS(TAPS), .SHIFT(2)) dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_ready(r_coef_ready));

  int total = 0;
  int bad   = 0;
  longint hist [TAPS];
  longint h    [TAPS];
  longint q0[$];
  longint q2[$];

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_sr(input longint a, input int sh);
    longint r, hi, lo;
    r = a;
    if (sh > 0) r = (a + (longint'(1) << (sh - 1))) >>> sh;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  task automatic model_accept(input longint x);
    longint s;
    s = 0;
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
    for (int i = 0; i < TAPS; i++) s += hist[i] * h[i];
    q0.push_back(model_sr(s, 0));
    q2.push_back(model_sr(s, 2));
  endtask

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin hist[i] = 0; h[i] = 0; end
    q0.delete();
    q2.delete();
  endtask

  task automatic wcoef(input int addr, input longint val);
    coef_we = 1'b1; coef_addr = AW'(addr); coef_data = COEF_W'(val);
    chk("coef_ready", coef_ready, 1);
    if (addr < TAPS) h[addr] = val;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Offer a sample (optionally with a coefficient write in the same cycle)
  task automatic send(input longint x, input bit we, input int addr, input longint val);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = IN_W'(x);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("send_wait", n < 100, 1);
    coef_we = we; coef_addr = AW'(addr); coef_data = COEF_W'(val);
    if (we && addr < TAPS) h[addr] = val;
    model_accept(x);
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  // Wait for an output, optionally hold it off for gap cycles, then take it
  task automatic recv(input int gap, input bit poke, output int lat,
                      output logic signed [63:0] got, output logic signed [63:0] got_r);
    int n;
    longint e0, e2;
    n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    lat = n + 1;
    chk("out_wait", out_valid, 1);
    chk("sb_have", q0.size() > 0, 1);
    e0 = (q0.size() > 0) ? q0.pop_front() : 0;
    e2 = (q2.size() > 0) ? q2.pop_front() : 0;
    for (int g = 0; g < gap; g++) begin
      chk("hold_data", out_data, e0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_coef_ready", coef_ready, 0);
      if (poke && g == 1) begin
        in_valid = 1'b1; in_data = 15'sd123;
        coef_we = 1'b1; coef_addr = '0; coef_data = 15'sd999;
      end else if (poke && g == 2) begin
        in_valid = 1'b0; coef_we = 1'b0;
      end
      @(negedge clk);
    end
    got = out_data; got_r = r_out_data;
    chk("out_data", out_data, e0);
    chk("out_data_r", r_out_data, e2);
    chk("out_valid_r", r_out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic signed [63:0] got, got_r;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_coef_ready", coef_ready, 1);

    // Impulse response with h[k]=k+1; out-of-range write must not land anywhere
    for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
    wcoef(13, 77);
    for (int i = 0; i < 21; i++) begin
      send((i == 0) ? 1 : 0, 1'b0, 0, 0);
      recv(0, 1'b0, lat, got, got_r);
      if (i == 0) chk("latency", lat, TAPS + 1);
      chk("impulse", got, (i < TAPS) ? i + 1 : 0);
    end

    // Backpressure: output held, in_valid pulse and coef write both ignored
    send(5, 1'b0, 0, 0);
    recv(5, 1'b1, lat, got, got_r);
    chk("bp_value", got, 5);
    for (int i = 0; i < TAPS; i++) begin
      send((i == 0) ? 1 : 0, 1'b0, 0, 0);
      recv(0, 1'b0, lat, got, got_r);
    end

    // Coefficient write in the accept cycle applies to that very sample
    send(2, 1'b1, 0, 7);
    recv(0, 1'b0, lat, got, got_r);
    chk("wr_and_accept", got, 14);

    // Saturation at both rails
    for (int i = 0; i < TAPS; i++) wcoef(i, 16383);
    for (int i = 0; i < TAPS; i++) begin
      send(16383, 1'b0, 0, 0);
      recv(0, 1'b0, lat, got, got_r);
    end
    chk("sat_hi", got, 524287);
    for (int i = 0; i < TAPS; i++) begin
      send(-16384, 1'b0, 0, 0);
      recv(0, 1'b0, lat, got, got_r);
    end
    chk("sat_lo", got, -524288);

    // Round-half-up on the SHIFT=2 instance
    wcoef(0, 1);
    for (int i = 1; i < TAPS; i++) wcoef(i, 0);
    send(6, 1'b0, 0, 0);  recv(0, 1'b0, lat, got, got_r); chk("round_p6", got_r, 2);
    send(-6, 1'b0, 0, 0); recv(0, 1'b0, lat, got, got_r); chk("round_m6", got_r, -1);
    send(5, 1'b0, 0, 0);  recv(0, 1'b0, lat, got, got_r); chk("round_p5", got_r, 1);

    // Reset in the middle of MAC at k=4
    send(100, 1'b0, 0, 0); recv(0, 1'b0, lat, got, got_r);
    send(7, 1'b0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < TAPS; i++) wcoef(i, i + 1);
    for (int i = 0; i < TAPS + 1; i++) begin
      send((i == 0) ? 1 : 0, 1'b0, 0, 0);
      recv(0, 1'b0, lat, got, got_r);
      chk("post_rst_impulse", got, (i < TAPS) ? i + 1 : 0);
    end

    // Random regression with output gaps; wptr wraps many times
    for (int i = 0; i < TAPS; i++) wcoef(i, longint'($urandom_range(0, 400)) - 200);
    for (int n = 0; n < 500; n++) begin
      send(longint'($urandom_range(0, 4000)) - 2000, 1'b0, 0, 0);
      recv(int'($urandom_range(0, 3)), 1'b0, lat, got, got_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
